// File: rtl/uart_frame_tx_pkg.sv
// Shared tags, frame constants and FSM encoding for the framed UART record sender.
`ifndef RstEnable
`define RstEnable 1'b0
`endif

package uart_frame_tx_pkg;

   localparam logic [1:0]  HDR_TAG         = 2'b10;
   localparam logic [1:0]  TRL_TAG         = 2'b11;
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_DONE
   } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB-first, stop bit, BAUD_DIV cycles each.
module uart_tx_byte
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 5208
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       done
);

   localparam int unsigned   BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned   NW        = $clog2(UART_FRAME_BITS);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(UART_FRAME_BITS - 1);

   logic          active_q, active_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [NW-1:0] bit_q, bit_d;
   logic [9:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          bit_end;
   logic          frame_end;

   assign bit_end   = active_q && (baud_q == BAUD_LAST);
   assign frame_end = bit_end && (bit_q == BIT_LAST);

   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      tx_d     = tx_q;
      if (active_q) begin
         if (bit_end) begin
            baud_d  = '0;
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b1, shreg_q[9:1]};
            tx_d    = shreg_q[1];
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
      if (frame_end) begin
         active_d = 1'b0;
         tx_d     = 1'b1;
      end
      // A start in the final stop-bit cycle chains the next byte with no idle gap.
      if (start && (!active_q || frame_end)) begin
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = '0;
         shreg_d  = {1'b1, din, 1'b0};
         tx_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn == `RstEnable) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign done = frame_end;

endmodule

// File: rtl/uart_frame_tx.sv
// Buffers {addr, data, kind} records in a small FIFO and sends each as a
// header / 7-bit payload / trailer byte stream on an 8N1 UART line.
module uart_frame_tx
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = 5208,
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_W-1:0]       in_addr,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [1:0]              in_kind,
   output logic                    tx,
   output logic                    busy,
   output logic                    frame_done,
   output logic [7:0]              drop_cnt
);

   localparam int unsigned   DW       = 8 * DATA_BYTES;
   localparam int unsigned   NBYTES   = DATA_BYTES + 2;
   localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW       = PW + 1;
   localparam int unsigned   IW       = $clog2(NBYTES);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DW-1:0]     data;
      logic [1:0]        kind;
   } rec_t;

   rec_t          in_rec;
   rec_t          fifo_q [FIFO_DEPTH];
   rec_t          fifo_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          in_ready_q, in_ready_d;
   logic          push;
   logic          pop;

   frame_state_e  state_q, state_d;
   rec_t          rec_q, rec_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;
   logic [7:0]    drop_q, drop_d;

   logic [7:0]    frame_c [NBYTES];
   logic [3:0]    msbs_c;
   logic [4:0]    addr5_c;
   logic [7:0]    trailer_c;
   logic          parity_c;

   logic          byte_start;
   logic [7:0]    byte_din;
   logic          byte_done;

   assign in_rec = {in_addr, in_data, in_kind};
   assign push   = in_valid && in_ready_q;
   assign pop    = (state_q == ST_IDLE) && (count_q != '0);

   always_comb begin
      fifo_d = fifo_q;
      if (push) fifo_d[wr_ptr_q] = in_rec;
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // Byte sequence is a pure function of the latched record, which only changes in IDLE.
   always_comb begin
      for (int unsigned k = 0; k < NBYTES; k++) frame_c[k] = '0;
      msbs_c  = '0;
      addr5_c = '0;
      addr5_c[ADDR_W-1:0] = rec_q.addr;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         frame_c[1+i] = {1'b0, rec_q.data[8*(DATA_BYTES-1-i) +: 7]};
         msbs_c[3-i]  = rec_q.data[8*(DATA_BYTES-1-i) + 7];
      end
      trailer_c = {TRL_TAG, rec_q.kind, msbs_c};
      parity_c  = trailer_c[0];
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         parity_c = parity_c ^ rec_q.data[8*i];
      end
      frame_c[0]        = {HDR_TAG, parity_c, addr5_c};
      frame_c[NBYTES-1] = trailer_c;
   end

   always_comb begin
      state_d    = state_q;
      rec_d      = rec_q;
      idx_d      = idx_q;
      byte_start = 1'b0;
      byte_din   = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_d     = drop_q;

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               rec_d   = fifo_q[rd_ptr_q];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            byte_start = 1'b1;
            byte_din   = frame_c[0];
            idx_d      = '0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (byte_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  byte_start = 1'b1;
                  byte_din   = frame_c[idx_q + 1'b1];
                  idx_d      = idx_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Ready reflects occupancy before any same-cycle pop, so a full FIFO refuses that push.
      in_ready_d   = (count_d != FULL_CNT);
      busy_d       = (state_d != ST_IDLE) || (count_d != '0);
      frame_done_d = (state_d == ST_DONE);
      if (in_valid && !in_ready_q && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (resetn == `RstEnable) begin
         state_q      <= ST_IDLE;
         rec_q        <= '0;
         idx_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         rec_q        <= rec_d;
         idx_q        <= idx_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         drop_q       <= drop_d;
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx_byte (
      .clk    (clk),
      .resetn (resetn),
      .start  (byte_start),
      .din    (byte_din),
      .tx     (tx),
      .done   (byte_done)
   );

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: 4-byte and 2-byte payload instances with a UART line decoder.
module tb_uart_frame_tx;

   localparam int unsigned B = 4;

   logic        clk = 1'b0;
   int unsigned cyc = 0;

   logic        rst4, v4, rdy4, tx4, busy4, fd4;
   logic [4:0]  a4;
   logic [31:0] d4;
   logic [1:0]  k4;
   logic [7:0]  drop4;

   logic        rst2, v2, rdy2, tx2, busy2, fd2;
   logic [4:0]  a2;
   logic [15:0] d2;
   logic [1:0]  k2;
   logic [7:0]  drop2;

   uart_frame_tx #(.BAUD_DIV(B), .DATA_BYTES(4), .ADDR_W(5), .FIFO_DEPTH(4)) dut4 (
      .clk(clk), .resetn(rst4), .in_valid(v4), .in_ready(rdy4), .in_addr(a4),
      .in_data(d4), .in_kind(k4), .tx(tx4), .busy(busy4), .frame_done(fd4), .drop_cnt(drop4)
   );

   uart_frame_tx #(.BAUD_DIV(B), .DATA_BYTES(2), .ADDR_W(5), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .resetn(rst2), .in_valid(v2), .in_ready(rdy2), .in_addr(a2),
      .in_data(d2), .in_kind(k2), .tx(tx2), .busy(busy2), .frame_done(fd2), .drop_cnt(drop2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          act;
      int unsigned c;
      logic [9:0]  sh;
   } rx_t;

   rx_t         rx [2];
   logic [7:0]  rxb4[$], rxb2[$];
   int unsigned rxs4[$], rxs2[$];
   int unsigned fdt4[$], fdt2[$];
   int unsigned stop_err = 0;

   // Line decoder: start detected at first low sample, each bit sampled mid-period.
   always @(negedge clk) begin
      logic [1:0] line;
      logic [1:0] rstn;
      line = {tx2, tx4};
      rstn = {rst2, rst4};
      for (int k = 0; k < 2; k++) begin
         if (!rstn[k]) begin
            rx[k].act = 1'b0;
         end else if (!rx[k].act) begin
            if (!line[k]) begin
               rx[k].act = 1'b1;
               rx[k].c   = 0;
               rx[k].sh  = '0;
               if (k == 0) rxs4.push_back(cyc); else rxs2.push_back(cyc);
            end
         end else begin
            rx[k].c++;
            if (rx[k].c % B == B / 2) begin
               rx[k].sh[rx[k].c / B] = line[k];
               if (rx[k].c / B == 9) begin
                  rx[k].act = 1'b0;
                  if (!rx[k].sh[9]) stop_err++;
                  if (k == 0) rxb4.push_back(rx[k].sh[8:1]); else rxb2.push_back(rx[k].sh[8:1]);
               end
            end
         end
      end
      if (fd4) fdt4.push_back(cyc);
      if (fd2) fdt2.push_back(cyc);
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      rxb4.delete(); rxs4.delete(); fdt4.delete();
      rxb2.delete(); rxs2.delete(); fdt2.delete();
   endtask

   task automatic push4(input logic [4:0] a, input logic [31:0] d, input logic [1:0] k);
      @(negedge clk);
      a4 = a; d4 = d; k4 = k; v4 = 1'b1;
      check_eq("push4_ready", rdy4, 1);
      @(posedge clk);
      #1 v4 = 1'b0;
   endtask

   task automatic push2(input logic [4:0] a, input logic [15:0] d, input logic [1:0] k);
      @(negedge clk);
      a2 = a; d2 = d; k2 = k; v2 = 1'b1;
      check_eq("push2_ready", rdy2, 1);
      @(posedge clk);
      #1 v2 = 1'b0;
   endtask

   task automatic wait_frames(input bit on2, input int unsigned n, input int unsigned budget,
                              input string tag);
      int unsigned got;
      got = on2 ? fdt2.size() : fdt4.size();
      for (int unsigned i = 0; i < budget && got < n; i++) begin
         @(posedge clk);
         got = on2 ? fdt2.size() : fdt4.size();
      end
      check_eq(tag, got, n);
   endtask

   logic [7:0] e1 [6] = '{8'h83, 8'h00, 8'h7F, 8'h01, 8'h02, 8'hDC};
   logic [7:0] e2 [6] = '{8'hBF, 8'h00, 8'h00, 8'h00, 8'h01, 8'hF0};
   logic [7:0] e3 [4] = '{8'h81, 8'h2B, 8'h4D, 8'hCC};
   logic [7:0] ovh [5] = '{8'h90, 8'hB1, 8'h92, 8'hB3, 8'h94};

   initial begin
      int unsigned bad;
      rst4 = 1'b0; v4 = 1'b0; a4 = '0; d4 = '0; k4 = '0;
      rst2 = 1'b0; v2 = 1'b0; a2 = '0; d2 = '0; k2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tx", tx4, 1);
      check_eq("rst_busy", busy4, 0);
      check_eq("rst_fd", fd4, 0);
      check_eq("rst_drop", drop4, 0);
      check_eq("rst_ready", rdy4, 1);
      check_eq("rst_tx2", tx2, 1);
      rst4 = 1'b1; rst2 = 1'b1;
      repeat (2) @(posedge clk);

      // Single record, 4-byte payload
      clear_q();
      push4(5'h03, 32'h80FF_0102, 2'b01);
      @(negedge clk);
      check_eq("t1_busy", busy4, 1);
      wait_frames(1'b0, 1, 600, "t1_frames");
      repeat (5) @(posedge clk);
      check_eq("t1_nbytes", rxb4.size(), 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("t1_byte%0d", i), rxb4[i], e1[i]);
      check_eq("t1_fd_count", fdt4.size(), 1);
      check_eq("t1_fd_delay", fdt4[0] - rxs4[0], 240);
      check_eq("t1_no_gap", rxs4[5] - rxs4[0], 200);

      // Parity set and kind in trailer
      clear_q();
      push4(5'h1F, 32'h0000_0001, 2'b11);
      wait_frames(1'b0, 1, 600, "t2_frames");
      repeat (5) @(posedge clk);
      check_eq("t2_nbytes", rxb4.size(), 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("t2_byte%0d", i), rxb4[i], e2[i]);

      // Overflow: 8 offered cycles, 5 accepted, 3 dropped
      clear_q();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a4 = 5'(16 + k); d4 = 32'(k); k4 = 2'b00; v4 = 1'b1;
      end
      @(negedge clk);
      v4 = 1'b0;
      check_eq("ov_ready_low", rdy4, 0);
      check_eq("ov_drop", drop4, 3);
      wait_frames(1'b0, 5, 1500, "ov_frames");
      repeat (60) @(posedge clk);
      @(negedge clk);
      check_eq("ov_nbytes", rxb4.size(), 30);
      check_eq("ov_fd_count", fdt4.size(), 5);
      for (int f = 0; f < 5; f++) begin
         check_eq($sformatf("ov_hdr%0d", f), rxb4[6*f], ovh[f]);
         check_eq($sformatf("ov_lsb%0d", f), rxb4[6*f+4], f);
         check_eq($sformatf("ov_trl%0d", f), rxb4[6*f+5], 8'hC0);
      end
      for (int f = 0; f < 4; f++)
         check_eq($sformatf("ov_gap%0d", f), rxs4[6*(f+1)] - rxs4[6*f+5], 10*B + 3);
      check_eq("ov_ready_back", rdy4, 1);
      check_eq("ov_busy_idle", busy4, 0);
      check_eq("ov_drop_hold", drop4, 3);

      // Two-byte payload instance
      clear_q();
      push2(5'h01, 16'hABCD, 2'b00);
      wait_frames(1'b1, 1, 400, "db2_frames");
      repeat (5) @(posedge clk);
      check_eq("db2_nbytes", rxb2.size(), 4);
      for (int i = 0; i < 4; i++) check_eq($sformatf("db2_byte%0d", i), rxb2[i], e3[i]);
      check_eq("db2_len", fdt2[0] - rxs2[0], 160);

      // Reset during the third byte's data bits
      clear_q();
      push4(5'h1F, 32'h0000_0001, 2'b11);
      for (int unsigned i = 0; i < 300 && rxs4.size() < 3; i++) @(posedge clk);
      check_eq("mr_third_start", rxs4.size(), 3);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_eq("mr_pre_tx", tx4, 0);
      check_eq("mr_pre_busy", busy4, 1);
      rst4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mr_tx", tx4, 1);
      check_eq("mr_busy", busy4, 0);
      check_eq("mr_ready", rdy4, 1);
      @(posedge clk);
      @(negedge clk);
      clear_q();
      rst4 = 1'b1;
      repeat (100) @(posedge clk);
      check_eq("mr_no_fd", fdt4.size(), 0);
      check_eq("mr_no_bytes", rxb4.size(), 0);
      push4(5'h03, 32'h80FF_0102, 2'b01);
      wait_frames(1'b0, 1, 600, "mr_frames");
      repeat (5) @(posedge clk);
      check_eq("mr_nbytes", rxb4.size(), 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("mr_byte%0d", i), rxb4[i], e1[i]);

      // Idle line
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx4 !== 1'b1 || busy4 !== 1'b0 || rdy4 !== 1'b1) bad++;
      end
      check_eq("idle_bad_cycles", bad, 0);
      check_eq("stop_bits", stop_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
